elipse_axil_slave: RTL and testbench

- AXI4-Lite slave register front-end of the ellipse processor; this is the block the master VIP drives on the S00_AXI port.
- Holds four 32-bit read/write parameter registers: REG0 = center X, REG1 = center Y, REG2 = semi-axis A, REG3 = semi-axis B.
- Exposes the four registers to the downstream ellipse core as static outputs.
- Emits a one-cycle start pulse whenever REG3 is written, which is the last parameter written in a sequential setup.

---
 rtl/elipse_axil_slave_if.sv | 51 +++++
 rtl/elipse_axil_slave.sv | 102 ++++++++++
 tb/tb_elipse_axil_slave.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/elipse_axil_slave_if.sv
// AXI4-Lite bus bundle for the ellipse processor S00_AXI port.
interface elipse_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/elipse_axil_slave.sv
// AXI4-Lite register front-end: four parameter registers for the ellipse core
// plus a start pulse fired by every write to REG3.
module elipse_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  elipse_axil_slave_if.slave            s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] center_x,
  output logic [C_S_AXI_DATA_WIDTH-1:0] center_y,
  output logic [C_S_AXI_DATA_WIDTH-1:0] axis_a,
  output logic [C_S_AXI_DATA_WIDTH-1:0] axis_b,
  output logic                          start
);
  localparam int NUM_REGS = 4;
  localparam int NBYTES   = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;

  logic                          aw_held, w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [NBYTES-1:0]             w_strb;
  logic                          awready, wready, bvalid, arready, rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs    <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;

      // Ready is a single-cycle pulse; the ~ready term stops a second accept
      // before the held flag has had a chance to block it.
      awready <= ~awready & s_axi.S_AXI_AWVALID & ~aw_held & ~bvalid;
      wready  <= ~wready  & s_axi.S_AXI_WVALID  & ~w_held  & ~bvalid;

      if (awready && s_axi.S_AXI_AWVALID) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.S_AXI_AWADDR[ADDR_LSB +: 2];
      end
      if (wready && s_axi.S_AXI_WVALID) begin
        w_held <= 1'b1;
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end

      if (aw_held && w_held) begin
        for (int k = 0; k < NBYTES; k++)
          if (w_strb[k]) regs[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        start   <= (aw_idx == 2'd3);
      end else if (bvalid && s_axi.S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end

      arready <= ~arready & s_axi.S_AXI_ARVALID & ~rvalid;
      // Capture reads regs before any same-edge write lands, so a colliding
      // read returns the pre-write value.
      if (arready && s_axi.S_AXI_ARVALID) begin
        rvalid <= 1'b1;
        rdata  <= regs[s_axi.S_AXI_ARADDR[ADDR_LSB +: 2]];
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign center_x = regs[0];
  assign center_y = regs[1];
  assign axis_a   = regs[2];
  assign axis_b   = regs[3];

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_elipse_axil_slave.sv
// Randomized AXI4-Lite bench for elipse_axil_slave: a transaction-level model
// predicts registers, responses and start, checked every cycle at negedge.
module tb_elipse_axil_slave;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] center_x, center_y, axis_a, axis_b;
  logic start;
  int cyc = 0;
  int total = 0, bad = 0;

  elipse_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  elipse_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus),
    .center_x(center_x), .center_y(center_y), .axis_a(axis_a), .axis_b(axis_b),
    .start(start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [4];
  bit          armed = 0;
  bit          m_aw_h, m_w_h;
  int          m_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;
  bit          e_bvalid, e_start, e_rvalid;
  logic [31:0] e_rdata;
  int          start_cnt = 0;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("bvalid", bus.S_AXI_BVALID, e_bvalid);
      chk("start", start, e_start);
      chk("rvalid", bus.S_AXI_RVALID, e_rvalid);
      if (e_rvalid) chk("rdata", bus.S_AXI_RDATA, e_rdata);
      chk("bresp", bus.S_AXI_BRESP, 0);
      chk("rresp", bus.S_AXI_RRESP, 0);
      chk("center_x", center_x, m_reg[0]);
      chk("center_y", center_y, m_reg[1]);
      chk("axis_a", axis_a, m_reg[2]);
      chk("axis_b", axis_b, m_reg[3]);
      chk("aw_accept_blocked", bus.S_AXI_AWVALID & bus.S_AXI_AWREADY & (e_bvalid | m_aw_h), 0);
      chk("w_accept_blocked", bus.S_AXI_WVALID & bus.S_AXI_WREADY & (e_bvalid | m_w_h), 0);
      if (start) start_cnt++;
    end
    // predict what the coming edge produces
    if (rst) begin
      armed = 1;
      foreach (m_reg[i]) m_reg[i] = 0;
      m_aw_h = 0; m_w_h = 0;
      e_bvalid = 0; e_start = 0; e_rvalid = 0; e_rdata = 0;
    end else if (armed) begin
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) begin
        e_rvalid = 1;
        e_rdata  = m_reg[bus.S_AXI_ARADDR[3:2]];
      end else if (e_rvalid && bus.S_AXI_RREADY) e_rvalid = 0;
      e_start = 0;
      if (m_aw_h && m_w_h) begin
        m_reg[m_idx] = (m_reg[m_idx] & ~strb_mask(m_ws)) | (m_wd & strb_mask(m_ws));
        e_bvalid = 1;
        e_start  = (m_idx == 3);
        m_aw_h = 0; m_w_h = 0;
      end else if (e_bvalid && bus.S_AXI_BREADY) e_bvalid = 0;
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) begin
        m_aw_h = 1; m_idx = int'(bus.S_AXI_AWADDR[3:2]);
      end
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) begin
        m_w_h = 1; m_wd = bus.S_AXI_WDATA; m_ws = bus.S_AXI_WSTRB;
      end
    end
  end

  // ---------------- bus driver tasks (drive at posedge+1) ----------------
  int hs_aw, hs_w;

  task automatic aw_phase(input logic [3:0] a, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.S_AXI_AWADDR = a; bus.S_AXI_AWPROT = 3'($urandom); bus.S_AXI_AWVALID = 1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < TMO);
    chk("aw_handshake", bus.S_AXI_AWREADY, 1);
    hs_aw = cyc + 1;
    @(posedge clk); #1; bus.S_AXI_AWVALID = 0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_WREADY && n < TMO);
    chk("w_handshake", bus.S_AXI_WREADY, 1);
    hs_w = cyc + 1;
    @(posedge clk); #1; bus.S_AXI_WVALID = 0;
  endtask

  task automatic write_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int daw, input int dw);
    fork
      aw_phase(a, daw);
      w_phase(d, s, dw);
    join
  endtask

  task automatic write_resp(input int hold);
    int n = 0;
    int last = (hs_aw > hs_w) ? hs_aw : hs_w;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_BVALID && n < TMO);
    chk("bvalid_seen", bus.S_AXI_BVALID, 1);
    chk("b_latency", cyc - last, 1);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.S_AXI_BREADY = 1;
    @(posedge clk); #1; bus.S_AXI_BREADY = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    write_req(a, d, s, 0, 0);
    write_resp(0);
  endtask

  task automatic rd(input logic [3:0] a, input int hold, output logic [31:0] d);
    int n = 0;
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARPROT = 3'($urandom); bus.S_AXI_ARVALID = 1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < TMO);
    chk("ar_handshake", bus.S_AXI_ARREADY, 1);
    @(posedge clk); #1; bus.S_AXI_ARVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_RVALID && n < TMO);
    chk("rvalid_seen", bus.S_AXI_RVALID, 1);
    d = bus.S_AXI_RDATA;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.S_AXI_RREADY = 1;
    @(posedge clk); #1; bus.S_AXI_RREADY = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1; rst = 1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] exp_init [4];
    int s0;
    bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
    exp_init[0] = 32'h1; exp_init[1] = 32'h2; exp_init[2] = 32'h3; exp_init[3] = 32'h4;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    chk("reset_awready", bus.S_AXI_AWREADY, 0);
    chk("reset_rdata", bus.S_AXI_RDATA, 0);
    chk("reset_axis_b", axis_b, 0);

    // sequential setup; start only on the REG3 write
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) write(4'(4 * i), exp_init[i], 4'hF);
    chk("start_before_reg3", start_cnt - s0, 0);
    write(4'hC, exp_init[3], 4'hF);
    chk("start_after_reg3", start_cnt - s0, 1);
    for (int i = 0; i < 4; i++) begin
      rd(4'(4 * i), 0, d);
      chk("readback", d, exp_init[i]);
    end
    chk("center_x_lit", center_x, 32'h1);
    chk("axis_b_lit", axis_b, 32'h4);

    // skewed AW/W ordering (latency checked inside write_resp)
    write_req(4'h0, 32'hCAFE0001, 4'hF, 0, 3); write_resp(0);
    write_req(4'h4, 32'hBEEF0002, 4'hF, 3, 0); write_resp(0);
    rd(4'h0, 0, d); chk("skew_aw_first", d, 32'hCAFE0001);
    rd(4'h5, 0, d); chk("skew_w_first_unaligned", d, 32'hBEEF0002);

    // byte strobes
    write(4'h4, 32'hAABBCCDD, 4'hF);
    write(4'h4, 32'h11223344, 4'h5);
    rd(4'h4, 0, d); chk("strobe_merge", d, 32'hAA22CC44);

    // BREADY held low stalls a queued second write
    write_req(4'h0, 32'h12345678, 4'hF, 0, 0);
    fork
      write_resp(5);
      write_req(4'h7, 32'h00009ABC, 4'hF, 0, 0);
    join
    write_resp(0);
    rd(4'h0, 0, d); chk("stall_first", d, 32'h12345678);
    rd(4'h4, 0, d); chk("stall_second", d, 32'h00009ABC);

    // read held while a write to the same register completes
    fork
      rd(4'h8, 4, d);
      begin write_req(4'h8, 32'h55, 4'hF, 0, 0); write_resp(0); end
    join
    chk("read_prewrite", d, 32'h3);
    rd(4'hA, 0, d); chk("read_postwrite", d, 32'h55);

    // reset with an address held and no data
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < TMO);
      chk("orphan_aw", bus.S_AXI_AWREADY, 1);
    end
    @(posedge clk); #1; bus.S_AXI_AWVALID = 0;
    do_reset(2);
    chk("post_reset_rdata", bus.S_AXI_RDATA, 0);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(4'(4 * i), 0, d);
      chk("post_reset_read", d, 0);
    end
    s0 = start_cnt;
    write(4'hF, 32'h77, 4'hF);
    chk("post_reset_start", start_cnt - s0, 1);
    rd(4'hC, 0, d); chk("post_reset_write", d, 32'h77);

    // zero strobe still answers and still fires start on REG3
    s0 = start_cnt;
    write(4'hC, 32'hFFFFFFFF, 4'h0);
    chk("zero_strobe_start", start_cnt - s0, 1);
    chk("zero_strobe_data", axis_b, 32'h77);

    // randomized traffic, checked by the model every cycle
    for (int it = 0; it < 60; it++) begin
      logic [3:0]  a  = 4'($urandom);
      logic [31:0] wd = $urandom;
      logic [3:0]  st = 4'($urandom);
      int da = $urandom_range(0, 3), dw = $urandom_range(0, 3);
      int bh = $urandom_range(0, 3), rh = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: begin write_req(a, wd, st, da, dw); write_resp(bh); end
        1: rd(4'($urandom), rh, d);
        default: fork
          begin write_req(a, wd, st, da, dw); write_resp(bh); end
          rd(4'($urandom), rh, d);
        join
      endcase
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
